// File: rtl/pwm_gen_core.sv
// pwm_gen_core
//   Counter-based PWM generator with a programmable prescaler and
//   double-buffered period/duty registers. New period/duty values are written
//   into shadow registers and only reach the active registers at a counter
//   wrap, so a PWM cycle in progress is never cut short or stretched.
//
// Ports
//   ck          system clock, rising edge
//   rst         asynchronous active-high reset
//   en          run enable; low holds the generator idle and counters at 0
//   presc_div   prescaler divisor; counter advances every presc_div+1 cycles
//   period_in   new period value (PWM cycle = period+1 ticks)
//   period_load one-cycle strobe, captures period_in into the period shadow
//   duty_in     new duty value (high for duty ticks per cycle)
//   duty_load   one-cycle strobe, captures duty_in into the duty shadow
//   pwm_out     registered PWM level
//   period_end  one-cycle pulse following each counter wrap
//   upd_pending a shadow value is waiting to be transferred

module pwm_gen_core #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic [PRE_W-1:0] presc_div,
  input  logic [WIDTH-1:0] period_in,
  input  logic             period_load,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_load,
  output logic             pwm_out,
  output logic             period_end,
  output logic             upd_pending
);

  logic [PRE_W-1:0] pre_cnt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] period_sh;
  logic [WIDTH-1:0] period_act;
  logic [WIDTH-1:0] duty_sh;
  logic [WIDTH-1:0] duty_act;

  logic tick;
  logic wrap;
  logic any_load;

  assign tick     = en && (pre_cnt == presc_div);
  assign wrap     = tick && (cnt == period_act);
  assign any_load = period_load || duty_load;

  // Prescaler and main counter
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else if (!en) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else begin
      if (tick) begin
        pre_cnt <= '0;
        if (wrap) cnt <= '0;
        else      cnt <= cnt + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  // Shadow registers load regardless of en; the active copy happens every
  // cycle while disabled so a fresh configuration is live before en rises.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      period_sh <= '1;
      duty_sh   <= '0;
    end else begin
      if (period_load) period_sh <= period_in;
      if (duty_load)   duty_sh   <= duty_in;
    end
  end

  // Transfer samples the shadows before this cycle's load takes effect, so a
  // load coinciding with a wrap is held over to the next wrap.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      period_act  <= '1;
      duty_act    <= '0;
      upd_pending <= 1'b0;
    end else if (!en) begin
      period_act  <= period_sh;
      duty_act    <= duty_sh;
      upd_pending <= 1'b0;
    end else begin
      if (wrap) begin
        period_act <= period_sh;
        duty_act   <= duty_sh;
      end
      if (any_load)  upd_pending <= 1'b1;
      else if (wrap) upd_pending <= 1'b0;
    end
  end

  // Output stage; duty_act > period_act naturally yields a constant high.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      pwm_out    <= 1'b0;
      period_end <= 1'b0;
    end else begin
      pwm_out    <= en && (cnt < duty_act);
      period_end <= wrap;
    end
  end

endmodule
